// File: rtl/branch_predictor_pkg.sv
// Shared counter encodings and saturating step helpers for the branch predictor.
// Counter MSB is the taken/not-taken prediction.
package branch_predictor_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BP_CNT_RESET = WNT;
  localparam logic [1:0] BP_CNT_ALLOC = WT;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    cnt_inc = (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    cnt_dec = (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// bp_table: direct-mapped BTB storage {valid, tag, target, cnt} with an async fetch read port,
// an async train read port, a sync write port on the train index, and async clear.
import branch_predictor_pkg::*;

module bp_table #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output logic [1:0]       rd_cnt,
  input  logic [IDX_W-1:0] tr_idx,
  output logic             tr_valid,
  output logic [TAG_W-1:0] tr_tag,
  output logic [31:0]      tr_target,
  output logic [1:0]       tr_cnt,
  input  logic             we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];

  assign tr_valid  = valid_q[tr_idx];
  assign tr_tag    = tag_q[tr_idx];
  assign tr_target = target_q[tr_idx];
  assign tr_cnt    = cnt_q[tr_idx];

  // Every write is either a hit update or an allocation, so valid is always set on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= BP_CNT_RESET;
      end
    end else if (we) begin
      valid_q[tr_idx]  <= 1'b1;
      tag_q[tr_idx]    <= wr_tag;
      target_q[tr_idx] <= wr_target;
      cnt_q[tr_idx]    <= wr_cnt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB + 2-bit counter predictor with EM-stage training and mispredict detection.
// Optional BP_STATS_EN adds saturating resolved-branch / mispredict counters.
import branch_predictor_pkg::*;

module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  output logic [31:0] PC_Predict,
  output logic        branch_taken,
  input  logic        EM_is_branch,
  input  logic [31:0] EM_PC,
  input  logic [31:0] EM_PCPlus4,
  input  logic        EM_PCSrc,
  input  logic [31:0] EM_PCBranch,
  input  logic        EM_pred_taken,
  input  logic [31:0] EM_pred_target,
  output logic        mispredict,
  output logic [31:0] PC_Recover,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  logic [IDX_W-1:0] f_idx, t_idx;
  logic [TAG_W-1:0] f_tag, t_tag;
  logic             f_valid, t_valid, f_hit, t_hit;
  logic [TAG_W-1:0] f_tag_q, t_tag_q;
  logic [31:0]      f_target, t_target;
  logic [1:0]       f_cnt, t_cnt;
  logic             we;
  logic [31:0]      wr_target;
  logic [1:0]       wr_cnt;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{PC[1:0], EM_PC[1:0]};

  assign f_idx = PC[IDX_W+1:2];
  assign f_tag = PC[31:IDX_W+2];
  assign t_idx = EM_PC[IDX_W+1:2];
  assign t_tag = EM_PC[31:IDX_W+2];

  bp_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (f_idx),
    .rd_valid  (f_valid),
    .rd_tag    (f_tag_q),
    .rd_target (f_target),
    .rd_cnt    (f_cnt),
    .tr_idx    (t_idx),
    .tr_valid  (t_valid),
    .tr_tag    (t_tag_q),
    .tr_target (t_target),
    .tr_cnt    (t_cnt),
    .we        (we),
    .wr_tag    (t_tag),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt)
  );

  // Lookup reads pre-update contents: no bypass from a same-cycle train.
  assign f_hit        = f_valid && (f_tag_q == f_tag);
  assign branch_taken = f_hit && f_cnt[1];
  assign PC_Predict   = branch_taken ? f_target : PC + 32'd4;

  assign mispredict = EM_is_branch &&
                      ((EM_pred_taken != EM_PCSrc) ||
                       (EM_PCSrc && (EM_pred_target != EM_PCBranch)));
  assign PC_Recover = EM_PCSrc ? EM_PCBranch : EM_PCPlus4;

  assign t_hit = t_valid && (t_tag_q == t_tag);

  // Miss + not-taken leaves the table alone so a cold not-taken branch never evicts anything.
  always_comb begin
    we        = 1'b0;
    wr_target = t_target;
    wr_cnt    = t_cnt;
    if (EM_is_branch) begin
      if (t_hit) begin
        we = 1'b1;
        if (EM_PCSrc) begin
          wr_cnt    = cnt_inc(t_cnt);
          wr_target = EM_PCBranch;
        end else begin
          wr_cnt = cnt_dec(t_cnt);
        end
      end else if (EM_PCSrc) begin
        we        = 1'b1;
        wr_cnt    = BP_CNT_ALLOC;
        wr_target = EM_PCBranch;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_q, mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (EM_is_branch && (br_q != 32'hFFFF_FFFF)) br_q <= br_q + 32'd1;
      if (mispredict && (mp_q != 32'hFFFF_FFFF))   mp_q <= mp_q + 32'd1;
    end
  end

  assign stat_branches = br_q;
  assign stat_mispred  = mp_q;
`else
  assign stat_branches = 32'h0;
  assign stat_mispred  = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes hand-computed expectations, monitor checks at negedge.
module tb_branch_predictor;

  localparam int W = 130;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC, PC_Predict, EM_PC, EM_PCPlus4, EM_PCBranch, EM_pred_target, PC_Recover;
  logic        branch_taken, EM_is_branch, EM_PCSrc, EM_pred_taken, mispredict;
  logic [31:0] stat_branches, stat_mispred;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_br = 0;
  int           exp_mp = 0;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC             (PC),
    .PC_Predict     (PC_Predict),
    .branch_taken   (branch_taken),
    .EM_is_branch   (EM_is_branch),
    .EM_PC          (EM_PC),
    .EM_PCPlus4     (EM_PCPlus4),
    .EM_PCSrc       (EM_PCSrc),
    .EM_PCBranch    (EM_PCBranch),
    .EM_pred_taken  (EM_pred_taken),
    .EM_pred_target (EM_pred_target),
    .mispredict     (mispredict),
    .PC_Recover     (PC_Recover),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {branch_taken, PC_Predict, mispredict, PC_Recover, stat_branches, stat_mispred};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got bt=%b pp=%h mp=%b rec=%h sb=%0d sm=%0d, want bt=%b pp=%h mp=%b rec=%h sb=%0d sm=%0d",
                 n, a[129], a[128:97], a[96], a[95:64], a[63:32], a[31:0],
                 e[129], e[128:97], e[96], e[95:64], e[63:32], e[31:0]);
      end
    end
  end

  // driver: apply one cycle of inputs and queue its expected combinational/stat outputs
  task automatic cyc(input logic [31:0] pc, input logic is_br, input logic [31:0] em_pc,
                     input logic src, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                     input logic e_bt, input logic [31:0] e_pp, input logic e_mp,
                     input logic [31:0] e_rec, input string name);
    logic [31:0] sb, sm;
    PC = pc; EM_is_branch = is_br; EM_PC = em_pc; EM_PCPlus4 = em_pc + 32'd4;
    EM_PCSrc = src; EM_PCBranch = tgt; EM_pred_taken = pt; EM_pred_target = ptgt;
`ifdef BP_STATS_EN
    sb = exp_br; sm = exp_mp;
`else
    sb = 32'h0; sm = 32'h0;
`endif
    exp_q.push_back({e_bt, e_pp, e_mp, e_rec, sb, sm});
    name_q.push_back(name);
    if (is_br) exp_br++;
    if (is_br && e_mp) exp_mp++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc, input logic e_bt, input logic [31:0] e_pp, input string name);
    cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, e_bt, e_pp, 1'b0, 32'h4, name);
  endtask

  initial begin
    rst_n = 1'b0;
    PC = 0; EM_is_branch = 0; EM_PC = 0; EM_PCPlus4 = 4; EM_PCSrc = 0;
    EM_PCBranch = 0; EM_pred_taken = 0; EM_pred_target = 0;
    @(posedge clk); #1;
    idle(32'h40, 1'b0, 32'h44, "in_reset");
    rst_n = 1'b1;
    idle(32'h40, 1'b0, 32'h44, "after_reset");

    // cold taken branch allocates WT; lookup in same cycle still misses
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h44, 1, 32'h100, "alloc_taken");
    idle(32'h40, 1'b1, 32'h100, "hit_after_alloc");
    // WT -> WNT -> SNT
    cyc(32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44, "nt1_pred_t");
    idle(32'h40, 1'b0, 32'h44, "after_nt1");
    cyc(32'h40, 1, 32'h40, 0, 32'h100, 0, 32'h44, 0, 32'h44, 0, 32'h44, "nt2_correct");
    idle(32'h40, 1'b0, 32'h44, "after_nt2");
    // SNT -> WNT -> WT -> ST -> ST (saturate)
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h44, 1, 32'h100, "tk1");
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h44, 1, 32'h100, "tk2");
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, "tk3");
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, "tk4");
    cyc(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, "tk5_sat");
    idle(32'h40, 1'b1, 32'h100, "after_sat");
    // one not-taken from ST must still predict taken (no wrap to SNT)
    cyc(32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44, "nt_from_st");
    idle(32'h40, 1'b1, 32'h100, "still_taken_wt");
    cyc(32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44, "nt_from_wt");
    idle(32'h40, 1'b0, 32'h44, "now_wnt");
    // wrong target: predicted 0x100, actual 0x200
    cyc(32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h100, 0, 32'h44, 1, 32'h200, "wrong_target");
    idle(32'h40, 1'b1, 32'h200, "new_target");
    // alias 0x80 replaces 0x40 at index 0
    cyc(32'h40, 1, 32'h80, 1, 32'h300, 0, 32'h84, 1, 32'h200, 1, 32'h300, "alias_alloc");
    idle(32'h40, 1'b0, 32'h44, "alias_old_miss");
    idle(32'h80, 1'b1, 32'h300, "alias_new_hit");
    // same-index lookup and train: old prediction visible this cycle
    cyc(32'h80, 1, 32'h80, 0, 32'h300, 1, 32'h300, 1, 32'h300, 1, 32'h84, "same_cycle_old");
    idle(32'h80, 1'b0, 32'h84, "same_cycle_new");
    // miss + not taken writes nothing
    cyc(32'h44, 1, 32'h44, 0, 32'h500, 0, 32'h48, 0, 32'h48, 0, 32'h48, "miss_nt");
    idle(32'h44, 1'b0, 32'h48, "miss_nt_nowrite");
    cyc(32'h44, 1, 32'h44, 1, 32'h500, 0, 32'h48, 0, 32'h48, 1, 32'h500, "idx1_alloc");
    idle(32'h44, 1'b1, 32'h500, "idx1_hit");
    idle(32'h80, 1'b0, 32'h84, "idx0_untouched");
    // bubble with disagreeing fields never flags
    cyc(32'h80, 0, 32'h0, 1, 32'h700, 0, 32'h0, 0, 32'h84, 0, 32'h700, "bubble_no_mp");
    idle(32'h80, 1'b0, 32'h84, "bubble_no_train");

    // async reset mid-run
    rst_n = 1'b0;
    exp_br = 0; exp_mp = 0;
    idle(32'h44, 1'b0, 32'h48, "mid_reset_low");
    rst_n = 1'b1;
    idle(32'h44, 1'b0, 32'h48, "mid_reset_after");
    cyc(32'h44, 1, 32'h44, 1, 32'h600, 0, 32'h48, 0, 32'h48, 1, 32'h600, "post_reset_alloc");
    idle(32'h44, 1'b1, 32'h600, "post_reset_hit");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
